// File: rtl/ofm_writeback_control_pkg.sv
// Shared constants, state encoding and sizing helper for the OFM writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofm_writeback_control_pkg;

  // One DDR beat is four 64-bit banks side by side.
  localparam int BEAT_W         = 256;
  localparam int BANKS_PER_BEAT = 4;
  localparam int SKID_DEPTH     = 4;

  // Controller states (plain constants so older tools and netlists can match them).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONF  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ofm_writeback_control_skid_fifo.sv
// Show-ahead FIFO holding returned buffer beats until the DDR write FIFO accepts them.
// Latency: a push is visible at the head on the next cycle; the head is combinational.
// Backpressure: the producer must never push while full; the top's credit rule guarantees it.
module ofm_skid_fifo
  import ofm_writeback_control_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  parameter int CNT_W = clogb2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = clogb2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Head is forced to zero when empty so the output bus is quiet after reset.
  assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty    = w_empty;
  assign o_count    = r_count;

  // Storage: data only, no reset needed since validity lives in the count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ofm_writeback_control.sv
// Streams a finished output tile from the banked output buffer into the DDR write FIFO, group-major.
// Latency: conf -> ddr_conf 1 cycle, -> first ob_en 2 cycles, -> first fifo write 2+RD_LAT cycles.
// Backpressure: ddr_fifo_full stalls the skid head; reads are throttled so inflight+skid never exceeds 4.
module ofm_writeback_control
  import ofm_writeback_control_pkg::*;
#(
  parameter int X_PE         = 16,
  parameter int X_MESH       = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int SINGLE_LEN   = 24,
  parameter int RD_LAT       = 2,
  parameter int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_conf,
  input  logic [SINGLE_LEN-1:0]          i_word_num,
  input  logic [DDR_ADDR_LEN-1:0]        i_ddr_st_addr,
  input  logic [ADDR_LEN-1:0]            i_ob_st_addr,
  output logic [DDR_ADDR_LEN-1:0]        o_ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]          o_ddr_len,
  output logic                           o_ddr_conf,
  output logic [ADDR_LEN-1:0]            o_ob_addr,
  output logic                           o_ob_en,
  input  logic [DATA_LEN*BUFFER_NUM-1:0] i_ob_rdata,
  input  logic                           i_ddr_fifo_full,
  output logic                           o_ddr_fifo_wr,
  output logic [BEAT_W-1:0]              o_ddr_fifo_data,
  output logic                           o_done,
  output logic                           o_idle
);

  localparam int G     = BUFFER_NUM / BANKS_PER_BEAT;
  localparam int TAG_W = clogb2(G);
  localparam int CNT_W = clogb2(SKID_DEPTH + 1);

  // Bytes transferred per unit of word_num: one beat from every group.
  localparam logic [SINGLE_LEN-1:0] LEN_PER_WORD = SINGLE_LEN'(G * BEAT_W / 8);

  typedef struct packed {
    logic [SINGLE_LEN-1:0] word_num;
    logic [ADDR_LEN-1:0]   ob_st_addr;
  } cfg_t;

  logic [1:0]              r_state;
  cfg_t                    r_cfg;
  logic [DDR_ADDR_LEN-1:0] r_ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   r_ddr_len;
  logic                    r_ddr_conf;
  logic                    r_done;
  logic [SINGLE_LEN-1:0]   r_a;
  logic [TAG_W-1:0]        r_g;
  logic [ADDR_LEN-1:0]     r_ob_addr;
  logic [CNT_W-1:0]        r_inflight;
  logic                    r_tag_vld [RD_LAT];
  logic [TAG_W-1:0]        r_tag     [RD_LAT];

  logic                    w_accept;
  logic                    w_issue_phase;
  logic [CNT_W:0]          w_credit_used;
  logic                    w_issue;
  logic                    w_last_a;
  logic                    w_last_issue;
  logic                    w_retire;
  logic                    w_drain_done;
  logic [BEAT_W-1:0]       w_beat;
  logic [BEAT_W-1:0]       w_skid_head;
  logic                    w_skid_empty;
  logic [CNT_W-1:0]        w_skid_count;
  logic                    w_wr;

  assign w_accept      = (r_state == ST_IDLE) && i_conf;
  assign w_issue_phase = (r_state == ST_CONF) || (r_state == ST_READ);
  // Reads in flight plus beats already parked must fit in the skid FIFO.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_skid_count};
  assign w_issue       = w_issue_phase && (w_credit_used < (CNT_W + 1)'(SKID_DEPTH));
  assign w_last_a      = (r_a == r_cfg.word_num - SINGLE_LEN'(1));
  assign w_last_issue  = w_issue && w_last_a && (r_g == TAG_W'(G - 1));
  assign w_retire      = r_tag_vld[RD_LAT-1];
  assign w_drain_done  = (r_state == ST_DRAIN) && (r_inflight == '0) && w_skid_empty;

  // The tag that rode along with the read selects which four banks form the beat.
  assign w_beat = i_ob_rdata[BEAT_W*r_tag[RD_LAT-1] +: BEAT_W];

  assign w_wr = !w_skid_empty && !i_ddr_fifo_full;

  assign o_ddr_st_addr_out = r_ddr_st_addr_out;
  assign o_ddr_len         = r_ddr_len;
  assign o_ddr_conf        = r_ddr_conf;
  assign o_ob_addr         = r_ob_addr;
  // Stage 0 of the tag pipe is exactly the registered read strobe.
  assign o_ob_en           = r_tag_vld[0];
  assign o_ddr_fifo_wr     = w_wr;
  assign o_ddr_fifo_data   = w_skid_head;
  assign o_done            = r_done;
  assign o_idle            = (r_state == ST_IDLE);

  // Control FSM: latch the job, pulse ddr_conf, issue reads, then wait for the pipe to empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= ST_IDLE;
      r_cfg             <= '0;
      r_ddr_st_addr_out <= '0;
      r_ddr_len         <= '0;
      r_ddr_conf        <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      r_ddr_conf <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_conf) begin
            r_cfg.word_num    <= i_word_num;
            r_cfg.ob_st_addr  <= i_ob_st_addr;
            r_ddr_st_addr_out <= i_ddr_st_addr;
            r_ddr_len         <= i_word_num * LEN_PER_WORD;
            // An empty job completes at once without touching the write master.
            if (i_word_num == '0) begin
              r_done <= 1'b1;
            end else begin
              r_ddr_conf <= 1'b1;
              r_state    <= ST_CONF;
            end
          end
        end
        ST_CONF:  r_state <= w_last_issue ? ST_DRAIN : ST_READ;
        ST_READ:  if (w_last_issue) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Address walk: a is the inner loop over beats, g the outer loop over groups.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a       <= '0;
      r_g       <= '0;
      r_ob_addr <= '0;
    end else if (w_accept) begin
      r_a <= '0;
      r_g <= '0;
    end else if (w_issue) begin
      r_ob_addr <= r_cfg.ob_st_addr + ADDR_LEN'(r_a);
      if (w_last_a) begin
        r_a <= '0;
        r_g <= r_g + TAG_W'(1);
      end else begin
        r_a <= r_a + SINGLE_LEN'(1);
      end
    end
  end

  // Tag pipe: carries the group index alongside each read until its data returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag[i]     <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag[0]     <= r_g;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag[i]     <= r_tag[i-1];
      end
    end
  end

  // Count of reads issued whose data has not yet landed in the skid FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= '0;
    end else if (w_issue && !w_retire) begin
      r_inflight <= r_inflight + CNT_W'(1);
    end else if (!w_issue && w_retire) begin
      r_inflight <= r_inflight - CNT_W'(1);
    end
  end

  ofm_skid_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (SKID_DEPTH),
    .CNT_W (CNT_W)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_retire),
    .i_push_dat (w_beat),
    .i_pop      (w_wr),
    .o_head_dat (w_skid_head),
    .o_empty    (w_skid_empty),
    .o_count    (w_skid_count)
  );

endmodule

// File: tb/tb_ofm_writeback_control.sv
// Randomized self-checking bench for ofm_writeback_control against a queue-based stream model.
// Latency: checks the conf/ob_en/first-write cycle offsets and sustained rate.
// Backpressure: drives ddr_fifo_full randomly and checks nothing is lost, duplicated or overflowed.
`timescale 1ns/1ps
module tb_ofm_writeback_control;

  localparam int DDR_ADDR_LEN = 32;
  localparam int ADDR_LEN     = 16;
  localparam int DATA_LEN     = 64;
  localparam int SINGLE_LEN   = 24;
  localparam int RD_LAT       = 2;
  localparam int X_PE         = 16;
  localparam int X_MESH       = 16;
  localparam int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN;
  localparam int G            = BUFFER_NUM / 4;

  logic                           i_clk = 1'b0;
  logic                           i_rst_n = 1'b0;
  logic                           i_conf = 1'b0;
  logic [SINGLE_LEN-1:0]          i_word_num = '0;
  logic [DDR_ADDR_LEN-1:0]        i_ddr_st_addr = '0;
  logic [ADDR_LEN-1:0]            i_ob_st_addr = '0;
  logic [DDR_ADDR_LEN-1:0]        o_ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]          o_ddr_len;
  logic                           o_ddr_conf;
  logic [ADDR_LEN-1:0]            o_ob_addr;
  logic                           o_ob_en;
  logic [DATA_LEN*BUFFER_NUM-1:0] i_ob_rdata;
  logic                           i_ddr_fifo_full = 1'b0;
  logic                           o_ddr_fifo_wr;
  logic [255:0]                   o_ddr_fifo_data;
  logic                           o_done;
  logic                           o_idle;

  always #5 i_clk = ~i_clk;

  ofm_writeback_control #(
    .X_PE(X_PE), .X_MESH(X_MESH), .DDR_ADDR_LEN(DDR_ADDR_LEN), .ADDR_LEN(ADDR_LEN),
    .DATA_LEN(DATA_LEN), .SINGLE_LEN(SINGLE_LEN), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_conf(i_conf), .i_word_num(i_word_num),
    .i_ddr_st_addr(i_ddr_st_addr), .i_ob_st_addr(i_ob_st_addr),
    .o_ddr_st_addr_out(o_ddr_st_addr_out), .o_ddr_len(o_ddr_len), .o_ddr_conf(o_ddr_conf),
    .o_ob_addr(o_ob_addr), .o_ob_en(o_ob_en), .i_ob_rdata(i_ob_rdata),
    .i_ddr_fifo_full(i_ddr_fifo_full), .o_ddr_fifo_wr(o_ddr_fifo_wr),
    .o_ddr_fifo_data(o_ddr_fifo_data), .o_done(o_done), .o_idle(o_idle)
  );

  // ---------------- buffer model: bank b at address A holds {salt, A, b} ----------------
  logic [31:0]         salt = 32'h0;
  logic                bm_vld = 1'b0;
  logic [ADDR_LEN-1:0] bm_addr = '0;

  function automatic logic [63:0] bank_word(input int b, input logic [15:0] addr, input logic [31:0] s);
    return {s, addr, 16'(b)};
  endfunction

  // Data for a read appears the cycle after ob_en (RD_LAT clock edges after the issue edge).
  always @(posedge i_clk) begin
    bm_vld  <= o_ob_en;
    bm_addr <= o_ob_addr;
  end

  always_comb begin
    i_ob_rdata = '0;
    for (int b = 0; b < BUFFER_NUM; b++)
      i_ob_rdata[DATA_LEN*b +: DATA_LEN] = bm_vld ? bank_word(b, bm_addr, salt) : 64'hBAD0_BAD0_FFFF_FFFF;
  end

  // Expected beat for group g at buffer address addr: banks 4g..4g+3, lowest bank in the low bits.
  function automatic logic [255:0] exp_beat(input int g, input logic [15:0] addr, input logic [31:0] s);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[64*k +: 64] = bank_word(4*g + k, addr, s);
    return r;
  endfunction

  logic [255:0] exp_q[$];
  logic [15:0]  exp_addr_q[$];

  task automatic build_exp(input int wn, input logic [15:0] ob);
    logic [15:0] ad;
    exp_q.delete();
    exp_addr_q.delete();
    for (int g = 0; g < G; g++)
      for (int a = 0; a < wn; a++) begin
        ad = ob + 16'(a);
        exp_q.push_back(exp_beat(g, ad, salt));
        exp_addr_q.push_back(ad);
      end
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic         mon_on = 1'b0;
  logic [255:0] got_q[$];
  logic [15:0]  en_addr_q[$];
  int n_conf, n_en, n_done, n_wr_full, max_skid;
  int conf_cyc, first_en_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
  logic [31:0] conf_addr;
  logic [23:0] conf_len;
  logic        conf_idle;

  always @(negedge i_clk) begin
    if (mon_on) begin
      if (o_ddr_conf) begin
        n_conf++; conf_cyc = cyc; conf_addr = o_ddr_st_addr_out; conf_len = o_ddr_len; conf_idle = o_idle;
      end
      if (o_ob_en) begin
        n_en++; en_addr_q.push_back(o_ob_addr);
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (o_ddr_fifo_wr) begin
        got_q.push_back(o_ddr_fifo_data); last_wr_cyc = cyc;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        if (i_ddr_fifo_full) n_wr_full++;
      end
      if (o_done) begin n_done++; done_cyc = cyc; end
      if (int'(dut.w_skid_count) > max_skid) max_skid = int'(dut.w_skid_count);
    end
  end

  task automatic clear_mon();
    got_q.delete(); en_addr_q.delete();
    n_conf = 0; n_en = 0; n_done = 0; n_wr_full = 0; max_skid = 0;
    conf_cyc = -1; first_en_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    conf_addr = '0; conf_len = '0; conf_idle = 1'bx;
  endtask

  function automatic int stream_errs();
    int e;
    e = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic int addr_errs();
    int e;
    e = (en_addr_q.size() != exp_addr_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_addr_q.size() && i < en_addr_q.size(); i++) if (en_addr_q[i] !== exp_addr_q[i]) e++;
    return e;
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  // Pulse conf, then run cycles (optionally toggling full / re-pulsing conf) until done or budget.
  task automatic run_transfer(input logic [23:0] wn, input logic [31:0] ddr, input logic [15:0] ob,
                              input bit rnd_full, input int repulse_at, output int c0, output bit timed_out);
    int k;
    clear_mon();
    mon_on = 1'b1;
    @(posedge i_clk); #1;
    i_word_num = wn; i_ddr_st_addr = ddr; i_ob_st_addr = ob; i_conf = 1'b1; i_ddr_fifo_full = 1'b0;
    c0 = cyc;
    @(posedge i_clk); #1;
    i_conf = 1'b0;
    k = 0;
    timed_out = 1'b1;
    while (k < 2000) begin
      if (n_done > 0) begin timed_out = 1'b0; break; end
      i_ddr_fifo_full = rnd_full ? 1'($urandom_range(0, 1)) : 1'b0;
      i_conf = (k == repulse_at);
      if (k == repulse_at) begin i_word_num = 24'd7; i_ddr_st_addr = $urandom; i_ob_st_addr = 16'h1234; end
      @(posedge i_clk); #1;
      k++;
    end
    i_conf = 1'b0;
    i_ddr_fifo_full = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    n_chk++; if (o_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", o_idle); else n_pass++;
    n_chk++; if ({o_ddr_conf, o_ob_en, o_ddr_fifo_wr, o_done} !== 4'b0)
      $display("FAIL reset_strobes: got conf/en/wr/done=%b expected 0000", {o_ddr_conf, o_ob_en, o_ddr_fifo_wr, o_done}); else n_pass++;
    n_chk++; if (o_ddr_len !== '0 || o_ddr_st_addr_out !== '0 || o_ob_addr !== '0 || o_ddr_fifo_data !== '0)
      $display("FAIL reset_buses: got len=%h addr=%h ob_addr=%h data_nonzero=%b expected all 0",
               o_ddr_len, o_ddr_st_addr_out, o_ob_addr, |o_ddr_fifo_data); else n_pass++;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int c0; bit to;
    salt = $urandom;
    build_exp(3, 16'h0010);
    run_transfer(24'd3, 32'h1000, 16'h0010, 1'b0, -1, c0, to);
    n_chk++; if (to !== 1'b0) $display("FAIL basic_timeout: done not seen within budget"); else n_pass++;
    n_chk++; if (n_conf !== 1) $display("FAIL basic_conf_count: got %0d expected 1", n_conf); else n_pass++;
    n_chk++; if (conf_cyc !== c0 + 1) $display("FAIL basic_conf_cycle: got %0d expected %0d", conf_cyc, c0 + 1); else n_pass++;
    n_chk++; if (conf_len !== 24'd768) $display("FAIL basic_ddr_len: got %0d expected 768", conf_len); else n_pass++;
    n_chk++; if (conf_addr !== 32'h1000) $display("FAIL basic_ddr_addr: got %h expected 00001000", conf_addr); else n_pass++;
    n_chk++; if (conf_idle !== 1'b0) $display("FAIL basic_idle_busy: got %b expected 0", conf_idle); else n_pass++;
    n_chk++; if (first_en_cyc !== c0 + 2) $display("FAIL basic_first_en: got %0d expected %0d", first_en_cyc, c0 + 2); else n_pass++;
    n_chk++; if (first_wr_cyc !== c0 + 2 + RD_LAT) $display("FAIL basic_first_wr: got %0d expected %0d", first_wr_cyc, c0 + 2 + RD_LAT); else n_pass++;
    n_chk++; if (got_q.size() !== 24) $display("FAIL basic_beat_count: got %0d expected 24", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL basic_beat%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 256'bx, exp_q[i]);
      else n_pass++;
    end
    n_chk++; if (last_wr_cyc - first_wr_cyc !== 23) $display("FAIL basic_sustained: got span %0d expected 23", last_wr_cyc - first_wr_cyc); else n_pass++;
    n_chk++; if (addr_errs() !== 0) $display("FAIL basic_ob_addr_seq: got %0d errors expected 0", addr_errs()); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL basic_done_count: got %0d expected 1", n_done); else n_pass++;
    n_chk++; if (o_idle !== 1'b1) $display("FAIL basic_idle_after: got %b expected 1", o_idle); else n_pass++;
  endtask

  task automatic test_backpressure();
    int c0; bit to;
    salt = $urandom;
    build_exp(3, 16'h0010);
    run_transfer(24'd3, 32'h1000, 16'h0010, 1'b1, -1, c0, to);
    n_chk++; if (to !== 1'b0) $display("FAIL bp_timeout: done not seen within budget"); else n_pass++;
    n_chk++; if (stream_errs() !== 0) $display("FAIL bp_stream: got %0d errors (%0d beats) expected 0 (24 beats)", stream_errs(), got_q.size()); else n_pass++;
    n_chk++; if (max_skid > 4) $display("FAIL bp_skid_max: got %0d expected <= 4", max_skid); else n_pass++;
    n_chk++; if (n_wr_full !== 0) $display("FAIL bp_wr_when_full: got %0d expected 0", n_wr_full); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL bp_done_count: got %0d expected 1", n_done); else n_pass++;
  endtask

  task automatic test_zero();
    int c0; bit to;
    run_transfer(24'd0, $urandom, 16'($urandom), 1'b0, -1, c0, to);
    n_chk++; if (n_conf !== 0) $display("FAIL zero_conf: got %0d expected 0", n_conf); else n_pass++;
    n_chk++; if (n_en !== 0) $display("FAIL zero_ob_en: got %0d expected 0", n_en); else n_pass++;
    n_chk++; if (done_cyc !== c0 + 1) $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, c0 + 1); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL zero_done_count: got %0d expected 1", n_done); else n_pass++;
    n_chk++; if (got_q.size() !== 0) $display("FAIL zero_writes: got %0d expected 0", got_q.size()); else n_pass++;
    n_chk++; if (o_idle !== 1'b1) $display("FAIL zero_idle: got %b expected 1", o_idle); else n_pass++;
  endtask

  task automatic test_repulse();
    int c0; bit to;
    salt = $urandom;
    build_exp(3, 16'h0010);
    run_transfer(24'd3, 32'h1000, 16'h0010, 1'b0, 4, c0, to);
    n_chk++; if (to !== 1'b0) $display("FAIL repulse_timeout: done not seen within budget"); else n_pass++;
    n_chk++; if (n_conf !== 1) $display("FAIL repulse_conf_count: got %0d expected 1", n_conf); else n_pass++;
    n_chk++; if (stream_errs() !== 0) $display("FAIL repulse_stream: got %0d errors expected 0", stream_errs()); else n_pass++;
    n_chk++; if (o_ddr_len !== 24'd768 || o_ddr_st_addr_out !== 32'h1000)
      $display("FAIL repulse_hold: got len=%0d addr=%h expected 768 00001000", o_ddr_len, o_ddr_st_addr_out); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL repulse_done_count: got %0d expected 1", n_done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0; bit to;
    logic [15:0] ob;
    clear_mon();
    mon_on = 1'b1;
    @(posedge i_clk); #1;
    i_word_num = 24'd4; i_ddr_st_addr = $urandom; i_ob_st_addr = 16'($urandom); i_conf = 1'b1;
    @(posedge i_clk); #1;
    i_conf = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    n_chk++; if (o_ob_en !== 1'b1) $display("FAIL rstmid_reading: got ob_en=%b expected 1", o_ob_en); else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_chk++; if (o_idle !== 1'b1) $display("FAIL rstmid_idle: got %b expected 1", o_idle); else n_pass++;
    n_chk++; if ({o_ddr_conf, o_ob_en, o_ddr_fifo_wr, o_done} !== 4'b0 || o_ddr_len !== '0 || o_ob_addr !== '0 || o_ddr_fifo_data !== '0)
      $display("FAIL rstmid_outputs: got conf/en/wr/done=%b len=%h ob_addr=%h expected all 0",
               {o_ddr_conf, o_ob_en, o_ddr_fifo_wr, o_done}, o_ddr_len, o_ob_addr); else n_pass++;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    salt = $urandom;
    ob = 16'($urandom);
    build_exp(2, ob);
    run_transfer(24'd2, $urandom, ob, 1'b0, -1, c0, to);
    n_chk++; if (to !== 1'b0) $display("FAIL rstmid_restart_timeout: done not seen within budget"); else n_pass++;
    n_chk++; if (en_addr_q.size() == 0 || en_addr_q[0] !== ob)
      $display("FAIL rstmid_first_addr: got %h expected %h", (en_addr_q.size() > 0) ? en_addr_q[0] : 16'hxxxx, ob); else n_pass++;
    n_chk++; if (stream_errs() !== 0) $display("FAIL rstmid_restart_stream: got %0d errors expected 0", stream_errs()); else n_pass++;
  endtask

  task automatic test_wrap();
    int c0; bit to;
    salt = $urandom;
    build_exp(2, 16'hFFFF);
    run_transfer(24'd2, 32'h2000, 16'hFFFF, 1'b0, -1, c0, to);
    n_chk++; if (to !== 1'b0) $display("FAIL wrap_timeout: done not seen within budget"); else n_pass++;
    n_chk++; if (addr_errs() !== 0) $display("FAIL wrap_ob_addr_seq: got %0d errors expected 0", addr_errs()); else n_pass++;
    n_chk++; if (en_addr_q.size() < 2 || en_addr_q[1] !== 16'h0000)
      $display("FAIL wrap_second_addr: got %h expected 0000", (en_addr_q.size() > 1) ? en_addr_q[1] : 16'hxxxx); else n_pass++;
    n_chk++; if (stream_errs() !== 0) $display("FAIL wrap_stream: got %0d errors expected 0", stream_errs()); else n_pass++;
  endtask

  task automatic test_random();
    int c0; bit to;
    int wn;
    logic [31:0] ddr;
    logic [15:0] ob;
    for (int it = 0; it < 3; it++) begin
      wn = $urandom_range(1, 5);
      ddr = $urandom;
      ob = 16'($urandom);
      salt = $urandom;
      build_exp(wn, ob);
      run_transfer(24'(wn), ddr, ob, 1'b1, -1, c0, to);
      n_chk++; if (to !== 1'b0 || n_done !== 1) $display("FAIL rand%0d_done: got timeout=%b done=%0d expected 0 1", it, to, n_done); else n_pass++;
      n_chk++; if (conf_len !== 24'(wn * G * 32) || conf_addr !== ddr)
        $display("FAIL rand%0d_conf: got len=%0d addr=%h expected %0d %h", it, conf_len, conf_addr, wn * G * 32, ddr); else n_pass++;
      n_chk++; if (stream_errs() !== 0) $display("FAIL rand%0d_stream: got %0d errors expected 0", it, stream_errs()); else n_pass++;
      n_chk++; if (max_skid > 4 || n_wr_full !== 0) $display("FAIL rand%0d_flow: got skid_max=%0d wr_when_full=%0d expected <=4 0", it, max_skid, n_wr_full); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_repulse();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
